// File: rtl/eth_tx_fcs_pkg.sv
// Shared definitions for the Ethernet TX framing stage: state encoding,
// frame constants and the reflected CRC-32 byte update used by the CRC block.
package eth_tx_fcs_pkg;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } tx_state_e;

  localparam int          ETH_MIN_FRAME_LEN = 60;
  localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [7:0]  ETH_PAD_BYTE      = 8'h00;

  // Bit-reflected (LSB-first) CRC-32 update for one byte, as sent on the wire.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_fcs_crc32.sv
// Byte-wide IEEE 802.3 CRC-32 with synchronous reset; crc_out is the
// complemented register, ready to be sent least-significant byte first.
module eth_tx_fcs_crc32
  import eth_tx_fcs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (data_valid) begin
      crc_d = crc32_next(crc_q, data_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= ETH_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = ~crc_q;

endmodule

// File: rtl/eth_tx_fcs.sv
// Ethernet TX framing stage: passes payload through, zero-pads short frames
// to the minimum length and appends the 4-byte FCS.
//
// state | meaning
// DATA  | payload pass-through, CRC fed with each accepted byte
// PAD   | emitting 0x00 until the frame reaches MIN_FRAME_LEN
// FCS   | emitting the four CRC bytes, LSB first; CRC frozen
module eth_tx_fcs
  import eth_tx_fcs_pkg::*;
#(
  parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
  parameter bit ENABLE_PAD    = 1'b1,
  parameter int CNT_WIDTH     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_last,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last
);

  localparam logic [CNT_WIDTH:0] MIN_LEN = (CNT_WIDTH + 1)'(MIN_FRAME_LEN);

  tx_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [1:0]           fcs_idx_q, fcs_idx_d;

  logic [CNT_WIDTH:0]   count_inc;
  logic                 out_xfer;
  logic                 crc_clear;
  logic                 crc_valid;
  logic                 crc_rst;
  logic [7:0]           crc_data;
  logic [31:0]          crc_out;

  // Outputs are combinational so DATA is a zero-latency pass-through;
  // reset forces the handshake low even before the first clock edge.
  always_comb begin
    m_data  = ETH_PAD_BYTE;
    m_valid = 1'b0;
    m_last  = 1'b0;
    s_ready = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        m_data  = s_data;
        m_valid = s_valid;
        s_ready = m_ready;
      end
      ST_PAD: begin
        m_valid = 1'b1;
      end
      ST_FCS: begin
        m_valid = 1'b1;
        m_last  = (fcs_idx_q == 2'd3);
        unique case (fcs_idx_q)
          2'd0:    m_data = crc_out[7:0];
          2'd1:    m_data = crc_out[15:8];
          2'd2:    m_data = crc_out[23:16];
          default: m_data = crc_out[31:24];
        endcase
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
    if (rst) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
      s_ready = 1'b0;
    end
  end

  assign out_xfer  = m_valid && m_ready;
  assign count_inc = {1'b0, count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    fcs_idx_d = fcs_idx_q;
    crc_clear = 1'b0;
    if (out_xfer) begin
      unique case (state_q)
        ST_DATA: begin
          count_d = (count_inc >= MIN_LEN) ? MIN_LEN[CNT_WIDTH-1:0]
                                           : count_inc[CNT_WIDTH-1:0];
          if (s_last) begin
            fcs_idx_d = 2'd0;
            state_d   = (ENABLE_PAD && (count_inc < MIN_LEN)) ? ST_PAD : ST_FCS;
          end
        end
        ST_PAD: begin
          count_d = count_inc[CNT_WIDTH-1:0];
          if (count_inc >= MIN_LEN) begin
            fcs_idx_d = 2'd0;
            state_d   = ST_FCS;
          end
        end
        ST_FCS: begin
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_d   = ST_DATA;
            count_d   = '0;
            crc_clear = 1'b1;
          end
        end
        default: begin
          state_d = ST_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DATA;
      count_q   <= '0;
      fcs_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      fcs_idx_q <= fcs_idx_d;
    end
  end

  // Clearing on the final FCS transfer leaves the CRC at its seed for the
  // very next frame byte, even when that byte arrives back-to-back.
  assign crc_valid = out_xfer && ((state_q == ST_DATA) || (state_q == ST_PAD));
  assign crc_data  = (state_q == ST_PAD) ? ETH_PAD_BYTE : s_data;
  assign crc_rst   = rst || crc_clear;

  eth_tx_fcs_crc32 u_crc32 (
    .clk        (clk),
    .rst        (crc_rst),
    .data_in    (crc_data),
    .data_valid (crc_valid),
    .crc_out    (crc_out)
  );

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Scoreboard bench for eth_tx_fcs: a table-driven CRC model builds each
// expected frame; a negedge monitor checks bytes, stalls, length and residue.
`timescale 1ns/1ps
module tb_eth_tx_fcs;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  always #5 clk = ~clk;

  eth_tx_fcs dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  int          len_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] crc_tab[256];
  bit          rnd_ready = 1'b0;
  logic [7:0]  p[$];
  logic [7:0]  p_keep[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  // Reference frame: payload, zero pad up to 60 bytes, then ~CRC LSB first.
  task automatic push_expected(input logic [7:0] pl[$]);
    logic [7:0]  frame[$];
    logic [31:0] c;
    beat_t       b;
    frame = pl;
    while (frame.size() < 60) frame.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (frame[i]) c = crc_upd(c, frame[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
    foreach (frame[i]) begin
      b.data = frame[i];
      b.last = (i == frame.size() - 1);
      exp_q.push_back(b);
    end
    len_q.push_back(frame.size());
  endtask

  // Monitor: runs mid-cycle, away from the active edge.
  logic [7:0]  frm[$];
  logic        stall_q = 1'b0;
  logic [7:0]  held_data;
  logic        held_last;
  beat_t       mon_e;
  logic [31:0] mon_c;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        frm.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", 32'(m_data), 32'(held_data));
          check("stall_last", 32'(m_last), 32'(held_last));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h with no expected byte", m_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("data", 32'(m_data), 32'(mon_e.data));
            check("last", 32'(m_last), 32'(mon_e.last));
          end
          frm.push_back(m_data);
          if (m_last) begin
            mon_c = 32'hFFFFFFFF;
            foreach (frm[i]) mon_c = crc_upd(mon_c, frm[i]);
            check("residue", mon_c, 32'hDEBB20E3);
            if (len_q.size() > 0) check("frame_len", 32'(frm.size()), 32'(len_q.pop_front()));
            frm.delete();
          end
        end
        stall_q   = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_valid && s_ready) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] pl[$]);
    push_expected(pl);
    foreach (pl[i]) begin
      s_valid = 1'b1;
      s_data  = pl[i];
      s_last  = (i == pl.size() - 1);
      wait_accept();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic rand_payload(input int len);
    p.delete();
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
  endtask

  initial begin
    build_table();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_m_last", 32'(m_last), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1-byte payload: 0xAA, 59 pad bytes, FCS
    p.delete();
    p.push_back(8'hAA);
    send_frame(p);
    wait_drain();

    // exactly minimum length: no pad
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    send_frame(p);
    wait_drain();

    // longer than minimum: count saturates
    rand_payload(100);
    send_frame(p);
    wait_drain();

    // 10-byte frame unstalled, then the same payload under random backpressure
    rand_payload(10);
    p_keep = p;
    send_frame(p);
    wait_drain();
    rnd_ready = 1'b1;
    send_frame(p_keep);
    wait_drain();
    rand_payload(75);
    send_frame(p);
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back frames: second s_valid already high after first m_last
    rand_payload(20);
    send_frame(p);
    rand_payload(70);
    send_frame(p);
    rand_payload(3);
    send_frame(p);
    wait_drain();

    // reset while padding frame 1, then a clean 60-byte frame 2
    rand_payload(5);
    send_frame(p);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_m_valid", 32'(m_valid), 32'd0);
    check("midreset_s_ready", 32'(s_ready), 32'd0);
    check("midreset_m_last", 32'(m_last), 32'd0);
    exp_q.delete();
    len_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rand_payload(60);
    send_frame(p);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
